instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Byte-stream instruction loader; the writer side of the pipeline's instruction-memory load port (`i_instruccion` / `i_address` / `i_loading`).
- Accepts bytes from the UART receiver over a valid/ready handshake and assembles them big-endian into 32-bit instruction words.
- Drives each word with its address and a write strobe into the fetch stage.
- Releases the load port when a halt word is written or the memory is full, so the pipeline can run.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- ADDR_INCR, 4, address step per written word (byte-addressed instruction memory).
- MAX_WORDS, 256, instruction memory depth in words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  begin a load session; sampled in IDLE and DONE only.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  loader can accept a byte.
- o_instruccion  out  DATA_WIDTH  assembled word to instruction memory.
- o_address  out  DATA_WIDTH  write address for o_instruccion.
- o_write  out  1  one-cycle write strobe.
- o_loading  out  1  high for the whole load session; pipeline held.
- o_done  out  1  load session finished.
- o_overflow  out  1  MAX_WORDS written without a HALT_WORD.
- o_word_count  out  $clog2(MAX_WORDS)+1  words written this session.
- o_chk_err  out  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset (asynchronous, i_reset=0):
  - state=IDLE.
  - All outputs 0; byte and word counters 0; shift register 0.
  - Applies mid-session as well: any partial word is discarded and no o_write is issued.
- States: IDLE, RECV, WRITE, DONE (plus CHK when the optional feature is enabled).
- IDLE:
  - o_rx_ready=0, o_loading=0.
  - i_start=1 -> RECV next cycle; counters cleared; o_loading=1 from that cycle.
- RECV:
  - o_rx_ready=1.
  - A byte transfers only when i_rx_valid & o_rx_ready; the word is shifted left 8 and the byte enters the LSB, so the first byte becomes bits [31:24].
  - byte_cnt counts 0..3. When the 4th byte is accepted at cycle N: byte_cnt wraps to 0 and the state is WRITE at N+1.
  - i_rx_valid low means hold; no timeout.
- WRITE (exactly one cycle):
  - o_rx_ready=0, o_write=1.
  - o_address = word_cnt*ADDR_INCR, computed modulo 2^DATA_WIDTH.
  - o_instruccion = assembled word.
  - o_instruccion and o_address keep their last values until the next WRITE.
  - word_cnt increments at the end of the cycle; o_word_count mirrors word_cnt.
- WRITE next-state priority:
  1. Word == HALT_WORD -> DONE. The halt word is still written.
  2. Else new word_cnt == MAX_WORDS -> DONE with o_overflow=1.
  3. Else -> RECV.
- DONE:
  - o_loading=0, o_done=1, o_rx_ready=0. Bytes arriving here are not accepted.
  - i_start=1 -> new session: o_done, o_overflow and o_chk_err cleared; counters zeroed; state RECV.
- i_start is ignored in RECV, WRITE and CHK.
- o_rx_ready is registered from the state only; it has no combinational dependence on i_rx_valid.
- Throughput: at most one byte per cycle; a word costs at least 5 cycles (4 RECV + 1 WRITE).

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted program byte is kept.
  - After the WRITE of HALT_WORD, the state goes to CHK (o_rx_ready=1) and accepts one checksum byte.
  - o_chk_err=1 if that byte != running XOR; the state then goes to DONE.
  - The overflow path skips CHK.
- Not defined: o_chk_err is tied 0, there is no CHK state, and HALT goes directly to DONE.

Test Plan:
1. Reset, pulse i_start, send 8'h20,8'h01,8'h00,8'h05 back-to-back, then FF,FF,FF,FF -> o_write at cycle after 4th byte with o_instruccion=32'h2001_0005, o_address=0; second write 32'hFFFF_FFFF at o_address=4; o_done=1, o_loading=0, o_word_count=2.
2. Send bytes with i_rx_valid toggling 1/0 each cycle -> identical writes to scenario 1; no byte lost or duplicated; o_rx_ready=0 during each WRITE cycle.
3. MAX_WORDS=4, send 16 non-halt bytes -> four writes at addresses 0,4,8,12; o_overflow=1, o_done=1; a 17th byte with i_rx_valid=1 is not accepted.
4. Drop i_reset after 2 of 4 bytes -> all outputs 0 immediately, no o_write; after release, i_start plus a full word writes to address 0.
5. In DONE pulse i_start, send 11,22,33,44,FF,FF,FF,FF -> flags clear, o_address restarts at 0, o_instruccion=32'h1122_3344.
6. With INSTR_LOADER_CHECKSUM_EN, program 01,02,03,04 + HALT, then checksum byte 8'h04 -> o_chk_err=0; repeat with 8'h05 -> o_chk_err=1, o_done=1.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs UART bytes big-endian into words and writes them to instruction memory.
// Optional trailing checksum byte after the halt word when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_INCR  = 4,
  parameter int MAX_WORDS  = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [7:0]                   i_rx_data,
  input  logic                         i_rx_valid,
  output logic                         o_rx_ready,
  output logic [DATA_WIDTH-1:0]        o_instruccion,
  output logic [DATA_WIDTH-1:0]        o_address,
  output logic                         o_write,
  output logic                         o_loading,
  output logic                         o_done,
  output logic                         o_overflow,
  output logic [$clog2(MAX_WORDS):0]   o_word_count,
  output logic                         o_chk_err
);

  localparam int CNT_W = $clog2(MAX_WORDS) + 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK   = 3'd4;
`endif

  logic [2:0]            state;
  logic [BC_W-1:0]       byte_cnt;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      next_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  overflow;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            xor_sum;
  logic                  chk_err;
`endif

  assign next_cnt  = word_cnt + CNT_W'(1);
  assign next_word = {shift_reg[DATA_WIDTH-9:0], i_rx_data};

  // Status outputs are pure decodes of the state register, so ready never depends on valid.
  assign o_write      = (state == WRITE);
  assign o_done       = (state == DONE);
  assign o_overflow   = overflow;
  assign o_word_count = word_cnt;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign o_rx_ready = (state == RECV) || (state == CHK);
  assign o_loading  = (state == RECV) || (state == WRITE) || (state == CHK);
  assign o_chk_err  = chk_err;
`else
  assign o_rx_ready = (state == RECV);
  assign o_loading  = (state == RECV) || (state == WRITE);
  assign o_chk_err  = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      shift_reg     <= '0;
      overflow      <= 1'b0;
      o_instruccion <= '0;
      o_address     <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_sum       <= '0;
      chk_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state     <= RECV;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            overflow  <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_sum   <= '0;
            chk_err   <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            shift_reg <= next_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_sum   <= xor_sum ^ i_rx_data;
`endif
            // Word and address are latched here so they are stable through WRITE and afterwards.
            if (byte_cnt == BC_W'(BYTES - 1)) begin
              byte_cnt      <= '0;
              state         <= WRITE;
              o_instruccion <= next_word;
              o_address     <= DATA_WIDTH'(word_cnt) * DATA_WIDTH'(ADDR_INCR);
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
        WRITE: begin
          word_cnt <= next_cnt;
          if (o_instruccion == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state <= DONE;
`endif
          end else if (next_cnt == CNT_W'(MAX_WORDS)) begin
            state    <= DONE;
            overflow <= 1'b1;
          end else begin
            state <= RECV;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        CHK: begin
          if (i_rx_valid) begin
            chk_err <= (i_rx_data != xor_sum);
            state   <= DONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-size loader plus a MAX_WORDS=4 loader for the overflow path.
// Checksum scenarios run only when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rdy, wr, loading, done, ovf, cerr;
  logic [31:0] instr, addr;
  logic [8:0]  wcnt;

  logic        s_start = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_rdy, s_wr, s_loading, s_done, s_ovf, s_cerr;
  logic [31:0] s_instr, s_addr;
  logic [2:0]  s_wcnt;

  instr_loader dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_rx_ready(rdy), .o_instruccion(instr), .o_address(addr),
    .o_write(wr), .o_loading(loading), .o_done(done), .o_overflow(ovf),
    .o_word_count(wcnt), .o_chk_err(cerr)
  );

  instr_loader #(.MAX_WORDS(4)) dut_small (
    .i_clock(clk), .i_reset(rst_n), .i_start(s_start), .i_rx_data(s_data),
    .i_rx_valid(s_valid), .o_rx_ready(s_rdy), .o_instruccion(s_instr), .o_address(s_addr),
    .o_write(s_wr), .o_loading(s_loading), .o_done(s_done), .o_overflow(s_ovf),
    .o_word_count(s_wcnt), .o_chk_err(s_cerr)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] s_exp_q[$];
  logic [7:0]  txor;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected {address, word}.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      chk("main_unexpected_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("main_addr", addr, e[63:32]);
        chk("main_instr", instr, e[31:0]);
        chk("main_ready_in_write", 32'(rdy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (s_wr === 1'b1) begin
      chk("small_unexpected_write", 32'(s_exp_q.size() != 0), 32'd1);
      if (s_exp_q.size() != 0) begin
        logic [63:0] e;
        e = s_exp_q.pop_front();
        chk("small_addr", s_addr, e[63:32]);
        chk("small_instr", s_instr, e[31:0]);
        chk("small_ready_in_write", 32'(s_rdy), 32'd0);
      end
    end
  end

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) s_start = 1'b1; else start = 1'b1;
    @(negedge clk);
    if (sel) s_start = 1'b0; else start = 1'b0;
    txor = '0;
    chk(sel ? "small_loading_after_start" : "main_loading_after_start",
        32'(sel ? s_loading : loading), 32'd1);
    chk(sel ? "small_ready_after_start" : "main_ready_after_start",
        32'(sel ? s_rdy : rdy), 32'd1);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (sel) begin s_data = b; s_valid = 1'b1; end
    else     begin rx_data = b; rx_valid = 1'b1; end
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((sel ? s_rdy : rdy) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    if (gap) begin
      @(negedge clk);
      if (sel) s_valid = 1'b0; else rx_valid = 1'b0;
    end
  endtask

  task automatic idle_rx(input bit sel);
    @(negedge clk);
    if (sel) s_valid = 1'b0; else rx_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input bit gap, input logic [31:0] a);
    if (sel) s_exp_q.push_back({a, w}); else exp_q.push_back({a, w});
    for (int k = 3; k >= 0; k--) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      if (!sel) txor = txor ^ b;
      send_byte(sel, b, gap);
    end
  endtask

  task automatic wait_done(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if ((sel ? s_done : done) === 1'b1) seen = 1'b1;
    end
    chk(sel ? "small_done_timeout" : "main_done_timeout", 32'(seen), 32'd1);
  endtask

  // Sends the correct checksum when the feature is built in, then waits for DONE.
  task automatic finish_session;
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(1'b0, txor, 1'b0);
`endif
    idle_rx(1'b0);
    wait_done(1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_write", 32'(wr), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_wcnt", 32'(wcnt), 32'd0);
    chk("rst_small_ovf", 32'(s_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: back-to-back bytes
    pulse_start(1'b0);
    send_word(1'b0, 32'h2001_0005, 1'b0, 32'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd4);
    finish_session();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_loading", 32'(loading), 32'd0);
    chk("s1_wcnt", 32'(wcnt), 32'd2);
    chk("s1_ovf", 32'(ovf), 32'd0);
    chk("s1_ready", 32'(rdy), 32'd0);
    chk("s1_chk_err", 32'(cerr), 32'd0);

    // Scenario 2: valid toggling every cycle
    pulse_start(1'b0);
    send_word(1'b0, 32'h2001_0005, 1'b1, 32'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b1, 32'd4);
    finish_session();
    chk("s2_wcnt", 32'(wcnt), 32'd2);
    chk("s2_done", 32'(done), 32'd1);

    // Scenario 3: overflow on the 4-word loader
    pulse_start(1'b1);
    send_word(1'b1, 32'h0102_0304, 1'b0, 32'd0);
    send_word(1'b1, 32'h0506_0708, 1'b0, 32'd4);
    send_word(1'b1, 32'h090A_0B0C, 1'b0, 32'd8);
    send_word(1'b1, 32'h0D0E_0F10, 1'b0, 32'd12);
    idle_rx(1'b1);
    wait_done(1'b1);
    chk("s3_ovf", 32'(s_ovf), 32'd1);
    chk("s3_wcnt", 32'(s_wcnt), 32'd4);
    @(negedge clk);
    s_data = 8'h55;
    s_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("s3_17th_ready", 32'(s_rdy), 32'd0);
    chk("s3_17th_wcnt", 32'(s_wcnt), 32'd4);
    chk("s3_17th_done", 32'(s_done), 32'd1);
    chk("s3_17th_instr", s_instr, 32'h0D0E_0F10);
    s_valid = 1'b0;
    pulse_start(1'b1);
    chk("s3_restart_ovf", 32'(s_ovf), 32'd0);
    chk("s3_restart_done", 32'(s_done), 32'd0);
    chk("s3_restart_wcnt", 32'(s_wcnt), 32'd0);

    // Scenario 4: reset mid-word
    pulse_start(1'b0);
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s4_loading", 32'(loading), 32'd0);
    chk("s4_ready", 32'(rdy), 32'd0);
    chk("s4_write", 32'(wr), 32'd0);
    chk("s4_instr", instr, 32'd0);
    chk("s4_addr", addr, 32'd0);
    chk("s4_wcnt", 32'(wcnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulse_start(1'b0);
    send_word(1'b0, 32'hA1B2_C3D4, 1'b0, 32'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd4);
    finish_session();
    chk("s4_wcnt_after", 32'(wcnt), 32'd2);

    // Scenario 5: restart from DONE
    pulse_start(1'b0);
    chk("s5_done_clear", 32'(done), 32'd0);
    chk("s5_wcnt_clear", 32'(wcnt), 32'd0);
    send_word(1'b0, 32'h1122_3344, 1'b0, 32'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd4);
    finish_session();
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_instr", instr, 32'hFFFF_FFFF);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Scenario 6: good then bad checksum
    pulse_start(1'b0);
    send_word(1'b0, 32'h0102_0304, 1'b0, 32'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd4);
    send_byte(1'b0, 8'h04, 1'b0);
    idle_rx(1'b0);
    wait_done(1'b0);
    chk("s6_good_chk_err", 32'(cerr), 32'd0);
    pulse_start(1'b0);
    send_word(1'b0, 32'h0102_0304, 1'b0, 32'd0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd4);
    send_byte(1'b0, 8'h05, 1'b0);
    idle_rx(1'b0);
    wait_done(1'b0);
    chk("s6_bad_chk_err", 32'(cerr), 32'd1);
    chk("s6_bad_done", 32'(done), 32'd1);
`else
    chk("chk_err_tied", 32'(cerr), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("main_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("small_queue_drained", 32'(s_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
